// File: rtl/conv_pool_seq.sv
// rtl/conv_pool_seq.sv - 5x5 convolution window sequencer with 2x2 max pooling; define CONV_POOL_RELU_EN to clamp pooled output at zero
module conv_pool_seq #(
    parameter int WIDTH   = 16,
    parameter int KERNELS = 6,
    parameter int IMG_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rd_en_o,
    output logic [49:0]          rd_addr_o,
    input  logic [5*WIDTH-1:0]   rd_data_i,
    output logic [25*WIDTH-1:0]  win_o,
    output logic                 win_valid_o,
    input  logic                 win_ready_i,
    output logic [7:0]           kernel_idx_o,
    input  logic                 res_valid_i,
    input  logic [WIDTH-1:0]     res_data_i,
    output logic                 wr_en_o,
    output logic [10:0]          wr_addr_o,
    output logic [WIDTH-1:0]     wr_data_o
);

    localparam int POOL_W = (IMG_W - 4) / 2;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t                  state;
    logic [2:0]              j;
    logic [1:0]              q;
    logic [7:0]              pr;
    logic [7:0]              pc;
    logic signed [WIDTH-1:0] run_max;

    logic [1:0]              q_nx;
    logic [7:0]              pc_nx;
    logic [7:0]              pr_nx;
    logic [7:0]              k_nx;
    logic                    last;
    logic signed [WIDTH-1:0] max_nx;
    logic [WIDTH-1:0]        pool_val;
    logic [10:0]             wr_addr_nx;

    // Five row addresses for a window whose top-left conv pixel is (row, col).
    function automatic logic [49:0] load_addr(input int row, input int col);
        logic [49:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) begin
            v[i*10 +: 10] = 10'((row + i) * IMG_W + col);
        end
        return v;
    endfunction

    // Next loop indices, running max including the current result, and the output word.
    always_comb begin
        q_nx  = q + 2'd1;
        pc_nx = pc + 8'd1;
        pr_nx = pr;
        k_nx  = kernel_idx_o;
        last  = 1'b0;
        if (int'(pc) == POOL_W - 1) begin
            pc_nx = '0;
            pr_nx = pr + 8'd1;
            if (int'(pr) == POOL_W - 1) begin
                pr_nx = '0;
                k_nx  = kernel_idx_o + 8'd1;
                if (int'(kernel_idx_o) == KERNELS - 1) begin
                    k_nx = '0;
                    last = 1'b1;
                end
            end
        end
        if (q == 2'd0 || $signed(res_data_i) > run_max) begin
            max_nx = $signed(res_data_i);
        end else begin
            max_nx = run_max;
        end
`ifdef CONV_POOL_RELU_EN
        pool_val = max_nx[WIDTH-1] ? '0 : max_nx;
`else
        pool_val = max_nx;
`endif
        wr_addr_nx = 11'(int'(kernel_idx_o) * POOL_W * POOL_W + int'(pr) * POOL_W + int'(pc));
    end

    // Sequencer: load window columns, hand window to the MAC, pool four results, write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            j            <= '0;
            q            <= '0;
            pr           <= '0;
            pc           <= '0;
            run_max      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            rd_en_o      <= 1'b0;
            rd_addr_o    <= '0;
            win_o        <= '0;
            win_valid_o  <= 1'b0;
            kernel_idx_o <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state        <= LOAD;
                        busy_o       <= 1'b1;
                        j            <= '0;
                        q            <= '0;
                        pr           <= '0;
                        pc           <= '0;
                        kernel_idx_o <= '0;
                        rd_en_o      <= 1'b1;
                        rd_addr_o    <= load_addr(0, 0);
                    end
                end
                LOAD: begin
                    // Data for the read issued at j-1 arrives now and fills column j-1.
                    if (j != 3'd0) begin
                        for (int i = 0; i < 5; i++) begin
                            win_o[(i*5 + int'(j) - 1)*WIDTH +: WIDTH] <= rd_data_i[i*WIDTH +: WIDTH];
                        end
                    end
                    if (j == 3'd4) begin
                        rd_en_o <= 1'b0;
                    end else if (j < 3'd4) begin
                        for (int i = 0; i < 5; i++) begin
                            rd_addr_o[i*10 +: 10] <= rd_addr_o[i*10 +: 10] + 10'd1;
                        end
                    end
                    if (j == 3'd5) begin
                        state       <= ISSUE;
                        win_valid_o <= 1'b1;
                    end
                    j <= j + 3'd1;
                end
                ISSUE: begin
                    if (win_ready_i) begin
                        win_valid_o <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (res_valid_i) begin
                        run_max <= max_nx;
                        if (q != 2'd3) begin
                            q         <= q_nx;
                            j         <= '0;
                            state     <= LOAD;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= load_addr(2*int'(pr) + int'(q_nx[1]), 2*int'(pc) + int'(q_nx[0]));
                        end else begin
                            state     <= WRITE;
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= wr_addr_nx;
                            wr_data_o <= pool_val;
                        end
                    end
                end
                WRITE: begin
                    wr_en_o      <= 1'b0;
                    q            <= '0;
                    pc           <= pc_nx;
                    pr           <= pr_nx;
                    kernel_idx_o <= k_nx;
                    if (last) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        state     <= LOAD;
                        j         <= '0;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= load_addr(2*int'(pr_nx), 2*int'(pc_nx));
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pool_seq.sv
// tb/tb_conv_pool_seq.sv - randomized self-checking bench for conv_pool_seq against a loop-order reference model
module tb_conv_pool_seq;

    localparam int WIDTH   = 16;
    localparam int KERNELS = 6;
    localparam int IMG_W   = 32;
    localparam int PW      = 14;
    localparam int NOUT    = KERNELS * PW * PW;
`ifdef CONV_POOL_RELU_EN
    localparam bit              RELU    = 1'b1;
    localparam logic [WIDTH-1:0] NEG_EXP = 16'h0000;
`else
    localparam bit              RELU    = 1'b0;
    localparam logic [WIDTH-1:0] NEG_EXP = 16'hFFFD;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                start_i;
    logic                busy_o;
    logic                done_o;
    logic                rd_en_o;
    logic [49:0]         rd_addr_o;
    logic [5*WIDTH-1:0]  rd_data_i;
    logic [25*WIDTH-1:0] win_o;
    logic                win_valid_o;
    logic                win_ready_i;
    logic [7:0]          kernel_idx_o;
    logic                res_valid_i;
    logic [WIDTH-1:0]    res_data_i;
    logic                wr_en_o;
    logic [10:0]         wr_addr_o;
    logic [WIDTH-1:0]    wr_data_o;

    always #5 clk = ~clk;

    conv_pool_seq #(.WIDTH(WIDTH), .KERNELS(KERNELS), .IMG_W(IMG_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .win_o(win_o), .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
        .kernel_idx_o(kernel_idx_o), .res_valid_i(res_valid_i), .res_data_i(res_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [WIDTH-1:0]        img [1024];
    logic [WIDTH-1:0]        forced [$];
    int                      exp_addr [$];
    logic [WIDTH-1:0]        exp_data [$];
    logic signed [WIDTH-1:0] grp [4];
    int  cyc, rd_total, acc_w, wr_cnt, done_cnt, first_rd_cyc;
    int  res_wait, rdy_wait, stall_w, pass_id;
    bit  rd_pend, res_pend, rdy_armed, rand_mode, stray_mode, chk_lat;
    logic [5*WIDTH-1:0]      rd_word;
    logic [WIDTH-1:0]        res_val;

    // Window w enumerates k, pr, pc, q in loop order; output index is w/4.
    function automatic void win_coords(input int w, output int r, output int c);
        int pr, pc, q;
        q  = w % 4;
        pc = (w / 4) % PW;
        pr = (w / (4 * PW)) % PW;
        r  = 2 * pr + q / 2;
        c  = 2 * pc + q % 2;
    endfunction

    function automatic logic [25*WIDTH-1:0] exp_win(input int w);
        logic [25*WIDTH-1:0] v;
        int r, c;
        win_coords(w, r, c);
        for (int i = 0; i < 5; i++)
            for (int jj = 0; jj < 5; jj++)
                v[(i*5 + jj)*WIDTH +: WIDTH] = img[10'((r + i) * IMG_W + c + jj)];
        return v;
    endfunction

    task automatic model_clear();
        rd_total = 0; acc_w = 0; wr_cnt = 0; done_cnt = 0; first_rd_cyc = 0;
        rd_pend = 0; res_pend = 0; rdy_armed = 0;
        exp_addr.delete(); exp_data.delete(); forced.delete();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 64'({busy_o, done_o, rd_en_o, win_valid_o, wr_en_o}), 64'd0);
        check({tag, "_rdaddr"}, 64'(rd_addr_o), 64'd0);
        check({tag, "_win"}, 64'(win_o == '0), 64'd1);
        check({tag, "_wr"}, 64'({kernel_idx_o, wr_addr_o, wr_data_o}), 64'd0);
    endtask

    // One clock: sample DUT outputs at the falling edge and drive the input buffer, MAC and handshakes.
    task automatic step();
        logic [95:0]         g;
        logic [49:0]         ea;
        logic [5*WIDTH-1:0]  word;
        logic signed [WIDTH-1:0] m;
        int r, c, w, jj;
        @(negedge clk);
        cyc++;
        g = {$urandom, $urandom, $urandom};
        rd_data_i = rd_pend ? rd_word : g[5*WIDTH-1:0];
        rd_pend = 0;
        if (rd_en_o) begin
            w  = rd_total / 5;
            jj = rd_total % 5;
            win_coords(w, r, c);
            for (int i = 0; i < 5; i++) ea[i*10 +: 10] = 10'((r + i) * IMG_W + c + jj);
            check("rd_addr", 64'(rd_addr_o), 64'(ea));
            if (pass_id == 1 && w == 783 && jj == 4) begin
                check("rd_row0_end", 64'(rd_addr_o[9:0]), 64'd895);
                check("rd_row4_end", 64'(rd_addr_o[49:40]), 64'd1023);
            end
            for (int i = 0; i < 5; i++) word[i*WIDTH +: WIDTH] = img[rd_addr_o[i*10 +: 10]];
            rd_word = word;
            rd_pend = 1;
            if (rd_total == 0) first_rd_cyc = cyc;
            rd_total++;
        end

        res_valid_i = 1'b0;
        res_data_i  = 16'($urandom);
        if (res_pend) begin
            if (res_wait == 0) begin
                res_valid_i = 1'b1;
                res_data_i  = res_val;
                res_pend    = 0;
            end else begin
                res_wait--;
            end
        end else if (stray_mode && $urandom_range(3) == 0) begin
            res_valid_i = 1'b1;
        end

        win_ready_i = 1'b0;
        if (win_valid_o) begin
            check("win", 64'(win_o == exp_win(acc_w)), 64'd1);
            if (!rdy_armed) begin
                rdy_armed = 1;
                rdy_wait  = (acc_w == stall_w) ? 10 : (rand_mode ? int'($urandom_range(3)) : 0);
            end
            if (rdy_wait == 0) begin
                win_ready_i = 1'b1;
            end else begin
                check("stall_rd_en", 64'(rd_en_o), 64'd0);
                rdy_wait--;
            end
            if (win_ready_i) begin
                check("kernel_idx", 64'(kernel_idx_o), 64'(acc_w / (4 * PW * PW)));
                res_pend = 1;
                res_wait = rand_mode ? int'($urandom_range(2, 1)) : 0;
                res_val  = (forced.size() > 0) ? forced.pop_front() : 16'($urandom);
                grp[acc_w % 4] = res_val;
                if (acc_w % 4 == 3) begin
                    m = grp[0];
                    for (int i = 1; i < 4; i++) if (grp[i] > m) m = grp[i];
                    if (RELU && m < 0) m = '0;
                    exp_addr.push_back(acc_w / 4);
                    exp_data.push_back(m);
                end
                rdy_armed = 0;
                acc_w++;
            end
        end else if (stray_mode) begin
            win_ready_i = 1'($urandom_range(1));
        end

        if (wr_en_o) begin
            if (exp_addr.size() == 0) begin
                check("wr_unexpected", 64'd1, 64'd0);
            end else begin
                check("wr_addr", 64'(wr_addr_o), 64'(exp_addr.pop_front()));
                check("wr_data", 64'(wr_data_o), 64'(exp_data.pop_front()));
            end
            if (chk_lat && wr_cnt == 0) check("latency", 64'(cyc - first_rd_cyc + 1), 64'd33);
            if ((pass_id == 1 || pass_id == 3) && wr_cnt == 0) begin
                check("first_addr", 64'(wr_addr_o), 64'd0);
            end
            if (pass_id == 1 && wr_cnt == 0) check("first_data", 64'(wr_data_o), 64'd5);
            if (pass_id == 1 && wr_cnt == 1) check("neg_pool", 64'(wr_data_o), 64'(NEG_EXP));
            wr_cnt++;
        end
        if (done_o) begin
            done_cnt++;
            check("done_busy", 64'(busy_o), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; win_ready_i = 1'b0; res_valid_i = 1'b0;
        res_data_i = '0; rd_data_i = '0;
        cyc = 0; pass_id = 0; stall_w = -1; rand_mode = 0; stray_mode = 0; chk_lat = 0;
        for (int i = 0; i < 1024; i++) img[i] = 16'($urandom);
        model_clear();
        repeat (3) step();
        check_quiet("reset");
        rst = 1'b0;

        // Full pass: immediate handshakes, fixed first results, one 10-cycle ready stall.
        pass_id = 1; stall_w = 5; chk_lat = 1;
        forced.push_back(16'd1);     forced.push_back(16'd5);
        forced.push_back(16'd3);     forced.push_back(16'd2);
        forced.push_back(16'hFFF9);  forced.push_back(16'hFFFD);
        forced.push_back(16'hFFF7);  forced.push_back(16'hFFFC);
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        for (int t = 0; t < 45000 && done_cnt == 0; t++) step();
        repeat (4) step();
        check("pass_done_cnt", 64'(done_cnt), 64'd1);
        check("pass_writes", 64'(wr_cnt), 64'(NOUT));
        check("pass_windows", 64'(acc_w), 64'(NOUT * 4));
        check("pass_pending", 64'(exp_addr.size()), 64'd0);
        check("busy_after_done", 64'(busy_o), 64'd0);

        // Random handshake delays, stray strobes, start while busy, then reset in WAIT of q=2.
        model_clear();
        pass_id = 2; stall_w = -1; rand_mode = 1; stray_mode = 1; chk_lat = 0;
        start_i = 1'b1;
        step();
        for (int t = 0; t < 3000 && acc_w < 11; t++) begin
            start_i = (t == 15);
            step();
        end
        start_i = 1'b0;
        check("reached_q2", 64'(acc_w), 64'd11);
        step();
        check("in_wait", 64'({win_valid_o, rd_en_o, wr_en_o}), 64'd0);
        check("pass2_writes", 64'(wr_cnt), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        for (int t = 0; t < 8; t++) begin
            step();
            check_quiet("post_abort");
        end
        check("abort_no_write", 64'(wr_cnt), 64'd0);
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // Restart begins from the first window and writes address 0 first.
        model_clear();
        pass_id = 3; rand_mode = 0; stray_mode = 0; chk_lat = 1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int t = 0; t < 200 && wr_cnt == 0; t++) step();
        check("restart_write", 64'(wr_cnt), 64'd1);
        rst = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_pool_seq.md
CONV_POOL_SEQ -- requirements
Module: conv_pool_seq

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter KERNELS, default 6, number of convolution kernels to sequence.
REQ-003 Parameter IMG_W, default 32, input image width and height in words; conv output is IMG_W-4 square, pooled output is (IMG_W-4)/2 square (default 14).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  one-cycle pulse that starts a layer pass.
REQ-007 busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-008 done_o  out  1  one-cycle pulse after the last pooled write.
REQ-009 rd_en_o  out  1  input-buffer read strobe.
REQ-010 rd_addr_o  out  5*10  five row addresses {row r+4 .. row r}, each row*IMG_W+col.
REQ-011 rd_data_i  in  5*WIDTH  five words, valid the cycle after rd_en_o.
REQ-012 win_o  out  25*WIDTH  5x5 window; word index row*5+col, row 0 in LSBs.
REQ-013 win_valid_o  out  1  window offered to the MAC unit.
REQ-014 win_ready_i  in  1  MAC unit accepts the window when high with win_valid_o.
REQ-015 kernel_idx_o  out  8  current kernel, drives kernel/bias ROM address.
REQ-016 res_valid_i  in  1  MAC result strobe.
REQ-017 res_data_i  in  WIDTH  MAC result, signed two's complement.
REQ-018 wr_en_o  out  1  output-buffer write strobe.
REQ-019 wr_addr_o  out  11  k*196+pr*14+pc (default sizes).
REQ-020 wr_data_o  out  WIDTH  pooled value.

Function
REQ-021 States IDLE, LOAD, ISSUE, WAIT, WRITE, DONE; IDLE->LOAD on start_i; start_i ignored when not IDLE.
REQ-022 Loop order outermost to innermost: kernel k, pooled row pr, pooled col pc, quadrant q 0..3; conv row r=2*pr+q[1], conv col c=2*pc+q[0].
REQ-023 LOAD lasts exactly 6 cycles, counter j=0..5: rd_en_o high for j=0..4 with column c+j; rd_data_i captured into window column j-1 at j=1..5; then ->ISSUE.
REQ-024 ISSUE: win_valid_o high and win_o stable until win_ready_i; the accepting cycle ->WAIT.
REQ-025 WAIT: first res_valid_i updates running max (q=0 loads it, q>0 keeps signed larger); ->LOAD for next q if q<3, else ->WRITE.
REQ-026 res_valid_i outside WAIT and win_ready_i outside ISSUE are ignored.
REQ-027 WRITE: wr_en_o high exactly one cycle with wr_addr_o and wr_data_o; then advance pc, wrap to pr, wrap to k; ->LOAD, or ->DONE after the last k/pr/pc.
REQ-028 DONE: done_o high one cycle, busy_o low, ->IDLE.
REQ-029 Equal results: either value is written (identical); max uses signed comparison over full WIDTH.
REQ-030 Minimum latency per pooled output 4*(6+1+1)+1 = 33 cycles with win_ready_i and res_valid_i returned immediately.

Reset
REQ-031 rst high forces IDLE, clears all counters, running max and window register to 0, and drives every output to 0 the following cycle.
REQ-032 rst mid-pass aborts without a write or done_o; a later start_i restarts from k=0, pr=0, pc=0, q=0.

Configuration
REQ-033 Macro CONV_POOL_RELU_EN defined: wr_data_o is max(pooled,0), so negative pooled values write 0.
REQ-034 Macro CONV_POOL_RELU_EN undefined: wr_data_o is the raw signed pooled max; all timing is identical in both builds.

Verification
REQ-035 Reset then start_i, ready/valid immediate, results 1,5,3,2 -> first write addr 0, data 5, 33 cycles after LOAD entry.
REQ-036 Quadrant results -7,-3,-9,-4 -> data 0xFFFD without CONV_POOL_RELU_EN; 0x0000 with it.
REQ-037 win_ready_i held low 10 cycles in ISSUE -> win_o unchanged and no rd_en_o during the stall; flow resumes on ready.
REQ-038 Full pass, default parameters -> exactly 1176 writes, addresses 0..1175 in order, one done_o, busy_o low afterwards.
REQ-039 Check read addresses at pr=13, pc=13, q=3 -> rd_addr_o row 0 column 31 = 27*32+31 = 895, row 4 = 31*32+31 = 1023.
REQ-040 rst asserted in WAIT of the q=2 conv, stray res_valid_i in IDLE, start_i pulsed while busy -> no write, no done, outputs 0; a restart begins at address 0.
